trap_redirect_unit: RTL and testbench
=====================================

# trap_redirect_unit

Consumes the exception report produced by the exception detection stage (`exception_flag`, `scause`, `sepc`) and the decoded `sret` signal, and carries out the supervisor-mode trap entry and return sequence. It owns the trap CSRs sstatus, stvec, sepc and scause, plus the current privilege bit. It also flushes the pipeline for a programmable number of cycles and then issues a single-cycle PC redirect to fetch. It sits between the exception detection stage, the CSR instruction path and the fetch unit.

## Interface
- `XLEN`, 64, address/data width
- `STVEC_RESET`, 64'h0000_0000_0000_0100, stvec value after reset
- `FLUSH_CYCLES`, 2, cycles `flush` is held before redirect (legal range 1..15)

- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `exception_flag`  in  1  exception reported this cycle
- `scause`  in  32  cause; bit 31 = interrupt, bits 30:0 = code
- `sepc`  in  XLEN  PC of faulting instruction
- `sret`  in  1  valid SRET decoded this cycle
- `csr_we`  in  1  CSR write strobe
- `csr_addr`  in  12  CSR address for read and write
- `csr_wdata`  in  XLEN  CSR write data
- `csr_rdata`  out  XLEN  combinational read of `csr_addr`; 0 for unmapped addresses
- `flush`  out  1  kill all in-flight instructions
- `redirect_valid`  out  1  one-cycle strobe; fetch loads `redirect_pc`
- `redirect_pc`  out  XLEN  redirect target
- `trap_active`  out  1  high while the FSM is not IDLE
- `priv_mode`  out  1  1 = S-mode, 0 = U-mode

## Operation
- CSR map:
  - sstatus 0x100: only bits SIE[1], SPIE[5] and SPP[8] are implemented; all others read 0 and ignore writes.
  - stvec 0x105: bits [1:0] are MODE; MODE values 2 and 3 are written as 0.
  - sepc 0x141: bit 0 always reads 0.
  - scause 0x142: zero-extended to XLEN.
- FSM states are IDLE, FLUSH and REDIRECT.
- IDLE with `exception_flag`=1 (trap entry):
  - sepc_csr <= `sepc` with bit 0 cleared.
  - scause_csr <= `scause`.
  - SPP <= priv; SPIE <= SIE; SIE <= 0; priv <= 1.
  - Target is computed from stvec as it is at the capture edge:
    - If MODE=1 and `scause`[31]=1: base + 4·code, where base = {stvec[XLEN-1:2],2'b00} and code = `scause`[30:0] zero-extended.
    - Otherwise: base.
  - Next state: FLUSH.
- IDLE with `sret`=1 and `exception_flag`=0 (trap return):
  - priv <= SPP; SIE <= SPIE; SPIE <= 1; SPP <= 0.
  - Target = sepc_csr.
  - Next state: FLUSH.
- If `exception_flag` and `sret` are asserted in the same cycle, the exception wins and `sret` is dropped.
- FLUSH:
  - `flush`=1.
  - Counter runs from 0 to FLUSH_CYCLES-1, then the FSM moves to REDIRECT.
- REDIRECT:
  - `redirect_valid`=1 and `redirect_pc`=target.
  - Next state: IDLE.
- `exception_flag` and `sret` are ignored outside IDLE; the pipeline is being flushed, so any report in that window is spurious.
- CSR writes are accepted in any state.
- On the trap-capture edge, trap updates override a concurrent `csr_we` to sepc, scause or sstatus. A concurrent stvec write does land, but the target already latched uses the old stvec.
- `redirect_pc` holds the last target when `redirect_valid`=0.

## Timing
- Reset (`reset`=0 at a rising edge):
  - FSM goes to IDLE.
  - stvec=STVEC_RESET; sepc_csr, scause_csr, sstatus and the counter = 0.
  - priv=1.
  - `flush`=0, `redirect_valid`=0, `redirect_pc`=0, `trap_active`=0.
- A reset asserted mid-sequence aborts it: no redirect is issued, and CSR updates already made are overwritten by reset values.
- Event sampled at edge N:
  - `flush` and `trap_active` are high in cycles N+1 .. N+FLUSH_CYCLES.
  - `redirect_valid` is high in cycle N+FLUSH_CYCLES+1.
  - IDLE again at N+FLUSH_CYCLES+2.
- The earliest next accepted event is at edge N+FLUSH_CYCLES+2.
- CSR state is visible on `csr_rdata` in the cycle after the capture edge.
- Total latency from event to redirect is FLUSH_CYCLES+1 cycles; back-to-back throughput is one event every FLUSH_CYCLES+2 cycles.

## Test plan
- Reset, then read CSRs:
  - stvec reads 0x100, all other CSRs read 0, `priv_mode`=1, all control outputs are 0.
- Illegal instruction, with stvec=0x8000_0000 (MODE 0):
  - Stimulus: `exception_flag`=1, `scause`=2, `sepc`=0x20.
  - Expected: `flush` high for 2 cycles, then `redirect_valid` with `redirect_pc`=0x8000_0000.
  - CSRs: sepc=0x20, scause=2, SIE=0.
- Misaligned PC, vectored interrupt and CSR write priority:
  - Misaligned `sepc`=0x31 stores sepc=0x30.
  - Vectored case: stvec=0x1001, `scause`=0x8000_0005 gives `redirect_pc`=0x1014.
  - Non-interrupt cause 5 with the same stvec gives 0x1000.
  - A same-cycle `csr_we` to scause loses to the trap.
- Round trip U→S→U:
  - Setup: write sstatus SIE=1, then perform SRET so that priv=0.
  - Take a trap (SPP=0, SPIE=1), then SRET.
  - Expected: `redirect_pc`=sepc_csr, priv=0, SIE=1, SPIE=1, SPP=0.
- Simultaneous and ignored events:
  - `exception_flag` and `sret` in the same cycle: trap entry occurs only.
  - A second `exception_flag` during FLUSH produces no extra redirect, and CSRs are unchanged.
- Reset mid-FLUSH:
  - No `redirect_valid` is issued and the FSM returns to IDLE.
  - With FLUSH_CYCLES=1, redirect follows exactly 2 cycles after the event.

Source files
------------

// File: rtl/trap_redirect_unit.sv
// trap_redirect_unit: supervisor trap entry/return CSRs, pipeline flush and single-cycle fetch redirect
module trap_redirect_unit #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] STVEC_RESET = 64'h0000_0000_0000_0100,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exception_flag,
  input  logic [31:0]     scause,
  input  logic [XLEN-1:0] sepc,
  input  logic            sret,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_active,
  output logic            priv_mode
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [XLEN-1:0] stvec, sepc_csr, target, base, vec_pc, sstatus;
  logic [31:0] scause_csr;
  logic sie, spie, spp, priv;
  assign base = {stvec[XLEN-1:2], 2'b00};
  assign vec_pc = (stvec[1:0] == 2'd1 && scause[31]) ? base + {{(XLEN-33){1'b0}}, scause[30:0], 2'b00} : base;
  assign sstatus = {{(XLEN-9){1'b0}}, spp, 2'b00, spie, 3'b000, sie, 1'b0};
  assign csr_rdata = csr_addr == 12'h100 ? sstatus :
                     csr_addr == 12'h105 ? stvec :
                     csr_addr == 12'h141 ? sepc_csr :
                     csr_addr == 12'h142 ? {{(XLEN-32){1'b0}}, scause_csr} : '0;
  assign flush = state == FLUSH;
  assign redirect_valid = state == REDIRECT;
  assign trap_active = state != IDLE;
  assign priv_mode = priv;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      stvec <= STVEC_RESET;
      sepc_csr <= '0;
      scause_csr <= '0;
      sie <= 1'b0;
      spie <= 1'b0;
      spp <= 1'b0;
      priv <= 1'b1;
      target <= '0;
      redirect_pc <= '0;
    end else begin
      if (csr_we && csr_addr == 12'h100) begin
        sie <= csr_wdata[1];
        spie <= csr_wdata[5];
        spp <= csr_wdata[8];
      end
      if (csr_we && csr_addr == 12'h105) stvec <= {csr_wdata[XLEN-1:2], csr_wdata[1] ? 2'b00 : csr_wdata[1:0]};
      if (csr_we && csr_addr == 12'h141) sepc_csr <= {csr_wdata[XLEN-1:1], 1'b0};
      if (csr_we && csr_addr == 12'h142) scause_csr <= csr_wdata[31:0];
      case (state)
        IDLE: begin
          if (exception_flag) begin
            sepc_csr <= {sepc[XLEN-1:1], 1'b0};
            scause_csr <= scause;
            spp <= priv;
            spie <= sie;
            sie <= 1'b0;
            priv <= 1'b1;
            target <= vec_pc;
            cnt <= '0;
            state <= FLUSH;
          end else if (sret) begin
            priv <= spp;
            sie <= spie;
            spie <= 1'b1;
            spp <= 1'b0;
            target <= sepc_csr;
            cnt <= '0;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt == 4'(FLUSH_CYCLES - 1)) begin
            redirect_pc <= target;
            state <= REDIRECT;
          end else cnt <= cnt + 4'd1;
        end
        REDIRECT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trap_redirect_unit.sv
// tb_trap_redirect_unit: directed checks of trap entry/return, flush timing and redirect targets
module tb_trap_redirect_unit;
  logic clk = 1'b0, reset, exception_flag, sret, csr_we;
  logic [31:0] scause;
  logic [63:0] sepc, csr_wdata, csr_rdata, redirect_pc, csr_rdata1, redirect_pc1;
  logic [11:0] csr_addr;
  logic flush, redirect_valid, trap_active, priv_mode;
  logic flush1, redirect_valid1, trap_active1, priv_mode1;
  int checks = 0, passes = 0, fails = 0;
  always #5 clk = ~clk;
  trap_redirect_unit #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .exception_flag(exception_flag), .scause(scause), .sepc(sepc),
    .sret(sret), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_active(trap_active), .priv_mode(priv_mode)
  );
  trap_redirect_unit #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .exception_flag(exception_flag), .scause(scause), .sepc(sepc),
    .sret(sret), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata1),
    .flush(flush1), .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
    .trap_active(trap_active1), .priv_mode(priv_mode1)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    csr_we = 1'b1;
    csr_addr = a;
    csr_wdata = d;
    step();
    csr_we = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask
  task automatic run(input string tag, input logic [63:0] exp_pc);
    step();
    exception_flag = 1'b0;
    sret = 1'b0;
    csr_we = 1'b0;
    chk({tag, " flush@1"}, {63'd0, flush}, 64'd1);
    chk({tag, " active@1"}, {63'd0, trap_active}, 64'd1);
    chk({tag, " rv@1"}, {63'd0, redirect_valid}, 64'd0);
    chk({tag, " flush1@1"}, {63'd0, flush1}, 64'd1);
    step();
    chk({tag, " flush@2"}, {63'd0, flush}, 64'd1);
    chk({tag, " rv@2"}, {63'd0, redirect_valid}, 64'd0);
    chk({tag, " rv1@2"}, {63'd0, redirect_valid1}, 64'd1);
    chk({tag, " pc1@2"}, redirect_pc1, exp_pc);
    step();
    chk({tag, " flush@3"}, {63'd0, flush}, 64'd0);
    chk({tag, " rv@3"}, {63'd0, redirect_valid}, 64'd1);
    chk({tag, " pc@3"}, redirect_pc, exp_pc);
    chk({tag, " rv1@3"}, {63'd0, redirect_valid1}, 64'd0);
    step();
    chk({tag, " active@4"}, {63'd0, trap_active}, 64'd0);
    chk({tag, " rv@4"}, {63'd0, redirect_valid}, 64'd0);
    chk({tag, " pc hold@4"}, redirect_pc, exp_pc);
  endtask
  initial begin
    reset = 1'b0;
    exception_flag = 1'b0;
    sret = 1'b0;
    csr_we = 1'b0;
    scause = '0;
    sepc = '0;
    csr_addr = '0;
    csr_wdata = '0;
    step();
    step();
    reset = 1'b1;
    rd("rst stvec", 12'h105, 64'h100);
    rd("rst sstatus", 12'h100, 64'h0);
    rd("rst sepc", 12'h141, 64'h0);
    rd("rst scause", 12'h142, 64'h0);
    rd("unmapped", 12'h7C0, 64'h0);
    chk("rst priv", {63'd0, priv_mode}, 64'd1);
    chk("rst flush", {63'd0, flush}, 64'd0);
    chk("rst rv", {63'd0, redirect_valid}, 64'd0);
    chk("rst pc", redirect_pc, 64'd0);
    chk("rst active", {63'd0, trap_active}, 64'd0);
    wr(12'h105, 64'h8000_0000);
    exception_flag = 1'b1;
    scause = 32'd2;
    sepc = 64'h20;
    run("illegal", 64'h8000_0000);
    rd("illegal sepc", 12'h141, 64'h20);
    rd("illegal scause", 12'h142, 64'h2);
    rd("illegal sstatus", 12'h100, 64'h100);
    exception_flag = 1'b1;
    scause = 32'd2;
    sepc = 64'h31;
    csr_we = 1'b1;
    csr_addr = 12'h142;
    csr_wdata = 64'h77;
    run("misaligned", 64'h8000_0000);
    rd("misaligned sepc", 12'h141, 64'h30);
    rd("csr_we loses", 12'h142, 64'h2);
    wr(12'h105, 64'h1001);
    rd("stvec vectored", 12'h105, 64'h1001);
    exception_flag = 1'b1;
    scause = 32'h8000_0005;
    sepc = 64'h40;
    run("vectored", 64'h1014);
    rd("vectored scause", 12'h142, 64'h8000_0005);
    exception_flag = 1'b1;
    scause = 32'd5;
    sepc = 64'h50;
    run("nonint", 64'h1000);
    wr(12'h105, 64'h2002);
    rd("stvec mode2", 12'h105, 64'h2000);
    wr(12'h100, 64'hFFFF_FFFF_FFFF_FEFF);
    rd("sstatus mask", 12'h100, 64'h22);
    sret = 1'b1;
    run("sret1", 64'h50);
    chk("sret1 priv", {63'd0, priv_mode}, 64'd0);
    rd("sret1 sstatus", 12'h100, 64'h22);
    exception_flag = 1'b1;
    scause = 32'd8;
    sepc = 64'h64;
    run("utrap", 64'h2000);
    chk("utrap priv", {63'd0, priv_mode}, 64'd1);
    rd("utrap sstatus", 12'h100, 64'h20);
    sret = 1'b1;
    run("sret2", 64'h64);
    chk("sret2 priv", {63'd0, priv_mode}, 64'd0);
    rd("sret2 sstatus", 12'h100, 64'h22);
    exception_flag = 1'b1;
    sret = 1'b1;
    scause = 32'd3;
    sepc = 64'h80;
    run("both", 64'h2000);
    chk("both priv", {63'd0, priv_mode}, 64'd1);
    rd("both sstatus", 12'h100, 64'h20);
    rd("both scause", 12'h142, 64'h3);
    exception_flag = 1'b1;
    scause = 32'd4;
    sepc = 64'h90;
    step();
    scause = 32'hD;
    sepc = 64'hA0;
    step();
    exception_flag = 1'b0;
    step();
    chk("ignored rv", {63'd0, redirect_valid}, 64'd1);
    chk("ignored pc", redirect_pc, 64'h2000);
    step();
    chk("ignored idle", {63'd0, trap_active}, 64'd0);
    step();
    chk("no extra rv", {63'd0, redirect_valid}, 64'd0);
    chk("no extra rv1", {63'd0, redirect_valid1}, 64'd0);
    chk("no extra flush", {63'd0, flush}, 64'd0);
    rd("ignored scause", 12'h142, 64'h4);
    rd("ignored sepc", 12'h141, 64'h90);
    rd("ignored sstatus", 12'h100, 64'h100);
    exception_flag = 1'b1;
    scause = 32'd2;
    sepc = 64'hB0;
    step();
    exception_flag = 1'b0;
    chk("midflush flush", {63'd0, flush}, 64'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("abort flush", {63'd0, flush}, 64'd0);
    chk("abort active", {63'd0, trap_active}, 64'd0);
    chk("abort rv", {63'd0, redirect_valid}, 64'd0);
    step();
    chk("abort rv+1", {63'd0, redirect_valid}, 64'd0);
    chk("abort rv1+1", {63'd0, redirect_valid1}, 64'd0);
    step();
    chk("abort rv+2", {63'd0, redirect_valid}, 64'd0);
    chk("abort pc", redirect_pc, 64'd0);
    rd("abort sepc", 12'h141, 64'h0);
    rd("abort stvec", 12'h105, 64'h100);
    chk("abort priv", {63'd0, priv_mode}, 64'd1);
    exception_flag = 1'b1;
    scause = 32'd1;
    sepc = 64'hC0;
    run("post reset", 64'h100);
    rd("post reset sepc", 12'h141, 64'hC0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
